// File: rtl/matvec_sequencer.sv
// Job sequencer for the 8x8 matrix-vector engine: fetches B and A-row words, unpacks them
// into the input FIFOs, then clears and runs the MAC chain. Optional cycle counter: MATVEC_SEQ_PERF_EN.
module matvec_sequencer #(
    parameter int unsigned ROWS         = 8,
    parameter int unsigned COLS         = 8,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DRAIN_CYCLES = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    output logic [ADDR_WIDTH-1:0]      mem_address,
    output logic                       mem_read,
    input  logic [COLS*DATA_WIDTH-1:0] mem_readdata,
    input  logic                       mem_readdatavalid,
    input  logic                       mem_waitrequest,
    output logic [DATA_WIDTH-1:0]      fifo_wdata,
    output logic                       fifo_wr_b,
    output logic [ROWS-1:0]            fifo_wr_a,
    input  logic                       fifo_full_b,
    input  logic [ROWS-1:0]            fifo_full_a,
    output logic                       mac_clr,
    output logic                       mac_en0,
    output logic                       fifo_rd_b,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [2:0]                 state,
    output logic [31:0]                perf_cycles
);
    localparam int unsigned WORD_W = COLS * DATA_WIDTH;
    localparam int unsigned WIDX_W = $clog2(ROWS + 1);
    localparam int unsigned BIDX_W = ($clog2(COLS) > 0) ? $clog2(COLS) : 1;
    localparam int unsigned DCNT_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_UNPACK = 3'd3;
    localparam logic [2:0] S_CLEAR  = 3'd4;
    localparam logic [2:0] S_RUN    = 3'd5;
    localparam logic [2:0] S_DRAIN  = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [WIDX_W-1:0]     word_idx_q, word_idx_d;
    logic [BIDX_W-1:0]     byte_idx_q, byte_idx_d;
    logic [DCNT_W-1:0]     drain_q, drain_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic                  err_q, err_d;
    logic [ROWS-1:0]       sel_a;
    logic                  tgt_full;
    logic                  start_ok;

    assign start_ok = start & ((state_q == S_IDLE) | (state_q == S_DONE));

    // Word 0 targets the B FIFO, word r+1 targets A FIFO r.
    always_comb begin
        sel_a = '0;
        for (int r = 0; r < ROWS; r++) begin
            sel_a[r] = (word_idx_q == WIDX_W'(r + 1));
        end
        tgt_full = (word_idx_q == '0) ? fifo_full_b : |(fifo_full_a & sel_a);
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        word_idx_d  = word_idx_q;
        byte_idx_d  = byte_idx_q;
        drain_d     = drain_q;
        word_d      = word_q;
        mem_read    = 1'b0;
        mem_address = '0;
        fifo_wdata  = '0;
        fifo_wr_b   = 1'b0;
        fifo_wr_a   = '0;
        mac_clr     = 1'b0;
        mac_en0     = 1'b0;
        fifo_rd_b   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    base_d     = base_addr;
                    word_idx_d = '0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_read    = 1'b1;
                mem_address = base_q + ADDR_WIDTH'(word_idx_q);
                if (!mem_waitrequest) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_readdatavalid) begin
                    word_d     = mem_readdata;
                    byte_idx_d = '0;
                    state_d    = S_UNPACK;
                end
            end
            S_UNPACK: begin
                // Latched word shifts left per written byte so the MSB byte is always next.
                fifo_wdata = word_q[WORD_W-1 -: DATA_WIDTH];
                if (!tgt_full) begin
                    fifo_wr_b  = (word_idx_q == '0);
                    fifo_wr_a  = sel_a;
                    word_d     = word_q << DATA_WIDTH;
                    byte_idx_d = byte_idx_q + BIDX_W'(1);
                    if (byte_idx_q == BIDX_W'(COLS - 1)) begin
                        byte_idx_d = '0;
                        if (word_idx_q == WIDX_W'(ROWS)) begin
                            state_d = S_CLEAR;
                        end else begin
                            word_idx_d = word_idx_q + WIDX_W'(1);
                            state_d    = S_FETCH;
                        end
                    end
                end
            end
            S_CLEAR: begin
                mac_clr    = 1'b1;
                byte_idx_d = '0;
                state_d    = S_RUN;
            end
            S_RUN: begin
                mac_en0    = 1'b1;
                fifo_rd_b  = 1'b1;
                byte_idx_d = byte_idx_q + BIDX_W'(1);
                if (byte_idx_q == BIDX_W'(COLS - 1)) begin
                    byte_idx_d = '0;
                    drain_d    = '0;
                    state_d    = S_DRAIN;
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + DCNT_W'(1);
                if (drain_q == DCNT_W'(DRAIN_CYCLES - 1)) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Return data outside WAIT_DATA is dropped and flagged until reset.
    assign err_d = err_q | (mem_readdatavalid & (state_q != S_WAIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            drain_q    <= '0;
            word_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            drain_q    <= drain_d;
            word_q     <= word_d;
            err_q      <= err_d;
        end
    end

    assign busy  = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done  = (state_q == S_DONE);
    assign err   = err_q;
    assign state = state_q;

`ifdef MATVEC_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    // The start-sampling cycle counts as the first busy cycle.
    always_comb begin
        perf_d = perf_q;
        if (start_ok)  perf_d = 32'd1;
        else if (busy) perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_matvec_sequencer.sv
// Scoreboard bench for matvec_sequencer: memory responder, FIFO-write monitor and directed jobs.
module tb_matvec_sequencer;
    localparam int ROWS = 8;
    localparam int COLS = 8;
`ifdef MATVEC_SEQ_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    typedef struct {
        int         tgt;
        logic [7:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [63:0] mem_readdata = '0;
    logic        mem_readdatavalid = 1'b0;
    logic        mem_waitrequest = 1'b0;
    logic [7:0]  fifo_wdata;
    logic        fifo_wr_b;
    logic [7:0]  fifo_wr_a;
    logic        fifo_full_b = 1'b0;
    logic [7:0]  fifo_full_a = '0;
    logic        mac_clr, mac_en0, fifo_rd_b, busy, done, err;
    logic [2:0]  state;
    logic [31:0] perf_cycles;

    int checks = 0;
    int errors = 0;
    int ecount = 0;
    logic [31:0] addr_q[$];
    wr_t         wq[$];

    int          job_id = 0, seen_job = 0;
    int          cfg_stall = 0, cfg_full = 0;
    logic [31:0] cfg_stall_addr = '0, cfg_full_addr = '0;
    int          stall_left = 0, full_skip = 0, full_left = 0;
    int          spur_cnt = 0, spur_seen = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = '0, last_addr = '1;
    int          clr_cnt = 0, clr_edge = 0, en_cnt = 0, en_first = 0, en_last = 0;
    bit          prev_en = 1'b0;

    matvec_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .mem_address(mem_address), .mem_read(mem_read), .mem_readdata(mem_readdata),
        .mem_readdatavalid(mem_readdatavalid), .mem_waitrequest(mem_waitrequest),
        .fifo_wdata(fifo_wdata), .fifo_wr_b(fifo_wr_b), .fifo_wr_a(fifo_wr_a),
        .fifo_full_b(fifo_full_b), .fifo_full_a(fifo_full_a), .mac_clr(mac_clr),
        .mac_en0(mac_en0), .fifo_rd_b(fifo_rd_b), .busy(busy), .done(done), .err(err),
        .state(state), .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecount <= ecount + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a, input int j);
        logic [31:0] v;
        v = ((a ^ 32'h10) & 32'hff) * 8 + 32'(j) + 32'd1;
        return v[7:0];
    endfunction

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        logic [63:0] w;
        for (int j = 0; j < COLS; j++) w[(COLS-1-j)*8 +: 8] = mem_byte(a, j);
        return w;
    endfunction

    // Memory and FIFO-full responder: drives inputs 1 time unit after each edge.
    always @(posedge clk) begin
        #1;
        if (job_id != seen_job) begin
            seen_job   = job_id;
            stall_left = cfg_stall;
            full_skip  = 2;
            full_left  = cfg_full;
        end
        mem_readdatavalid = 1'b0;
        if (pend) begin
            mem_readdatavalid = 1'b1;
            mem_readdata      = mem_word(pend_addr);
            pend              = 1'b0;
        end else if (spur_cnt != spur_seen) begin
            mem_readdatavalid = 1'b1;
            mem_readdata      = '1;
            spur_seen         = spur_cnt;
        end
        mem_waitrequest = 1'b0;
        if (mem_read) begin
            if (stall_left > 0 && mem_address == cfg_stall_addr) begin
                mem_waitrequest = 1'b1;
                stall_left--;
            end
            if (addr_q.size() == 0) chk("rd_unexpected", 64'(mem_address), 64'hdead);
            else                    chk("rd_addr", 64'(mem_address), 64'(addr_q[0]));
            if (!mem_waitrequest) begin
                pend      = 1'b1;
                pend_addr = mem_address;
                last_addr = mem_address;
                if (addr_q.size() != 0) void'(addr_q.pop_front());
            end
        end
        fifo_full_a = '0;
        if (state == 3'd3 && last_addr == cfg_full_addr && cfg_full > 0) begin
            if (full_skip > 0) full_skip--;
            else if (full_left > 0) begin
                fifo_full_a[2] = 1'b1;
                full_left--;
            end
        end
    end

    // Output monitor: FIFO writes against the scoreboard, MAC strobe bookkeeping.
    always @(posedge clk) begin
        int n_wr, tgt;
        wr_t e;
        #3;
        n_wr = $countones({fifo_wr_b, fifo_wr_a});
        if (n_wr != 0) begin
            chk("wr_onehot", 64'(n_wr), 64'd1);
            chk("wr_to_full", 64'(|({fifo_wr_b, fifo_wr_a} & {fifo_full_b, fifo_full_a})), 64'd0);
            tgt = 0;
            for (int r = 0; r < ROWS; r++) if (fifo_wr_a[r]) tgt = r + 1;
            if (wq.size() == 0) chk("wr_unexpected", 64'(tgt), 64'hdead);
            else begin
                e = wq.pop_front();
                chk("wr_tgt", 64'(tgt), 64'(e.tgt));
                chk("wr_data", 64'(fifo_wdata), 64'(e.data));
            end
        end
        if (mac_clr) begin
            clr_cnt++;
            clr_edge = ecount;
        end
        if (mac_en0 || fifo_rd_b) begin
            chk("rd_b_vs_en", 64'(fifo_rd_b), 64'(mac_en0));
            if (!prev_en) en_first = ecount;
            en_last = ecount;
            en_cnt++;
        end
        prev_en = mac_en0;
    end

    task automatic push_job(input logic [31:0] base);
        wr_t e;
        for (int w = 0; w <= ROWS; w++) begin
            addr_q.push_back(base + 32'(w));
            for (int j = 0; j < COLS; j++) begin
                e.tgt  = w;
                e.data = mem_byte(base + 32'(w), j);
                wq.push_back(e);
            end
        end
    endtask

    task automatic pulse_start(input logic [31:0] base, output int start_edge);
        start     = 1'b1;
        base_addr = base;
        @(posedge clk);
        #4;
        start      = 1'b0;
        start_edge = ecount;
    endtask

    task automatic run_job(input logic [31:0] base, input int stall, input int full,
                           input bit start_in_run, input logic exp_err);
        int se, c0, e0, done_rel, d;
        bit pulsed, seen;
        d              = stall + full;
        cfg_stall      = stall;
        cfg_stall_addr = base + 32'd3;
        cfg_full       = full;
        cfg_full_addr  = base + 32'd3;
        push_job(base);
        job_id++;
        c0 = clr_cnt;
        e0 = en_cnt;
        pulse_start(base, se);
        pulsed = 1'b0;
        seen   = 1'b0;
        done_rel = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #4;
            if (start) begin
                start     = 1'b0;
                base_addr = base;
            end
            if (done) begin
                seen     = 1'b1;
                done_rel = ecount - se + 1;
                break;
            end
            if (start_in_run && !pulsed && state == 3'd5) begin
                start     = 1'b1;
                base_addr = 32'h999;
                pulsed    = 1'b1;
            end
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("done_cycle", 64'(done_rel), 64'(110 + d));
        chk("clr_count", 64'(clr_cnt - c0), 64'd1);
        chk("clr_cycle", 64'(clr_edge - se + 1), 64'(91 + d));
        chk("en_count", 64'(en_cnt - e0), 64'd8);
        chk("en_first", 64'(en_first - se + 1), 64'(92 + d));
        chk("en_last", 64'(en_last - se + 1), 64'(99 + d));
        chk("perf", 64'(perf_cycles), PERF_ON ? 64'(110 + d) : 64'd0);
        chk("busy_done", 64'(busy), 64'd0);
        chk("err", 64'(err), 64'(exp_err));
        chk("addr_left", 64'(addr_q.size()), 64'd0);
        chk("wr_left", 64'(wq.size()), 64'd0);
    endtask

    initial begin
        int se;
        bit hit;
        #12;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_outs_a", {mem_address, mem_read, fifo_wdata, fifo_wr_b, fifo_wr_a, mac_clr,
                           mac_en0, fifo_rd_b, busy, done, err}, 64'd0);
        chk("rst_perf", 64'(perf_cycles), 64'd0);
        @(posedge clk);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #4;

        run_job(32'h10, 0, 0, 1'b0, 1'b0);
        run_job(32'h20, 5, 0, 1'b0, 1'b0);
        run_job(32'h30, 0, 4, 1'b0, 1'b0);

        // Job that wraps the address space, abandoned by reset during word 5 unpack.
        cfg_stall = 0;
        cfg_full  = 0;
        push_job(32'hFFFF_FFFC);
        job_id++;
        pulse_start(32'hFFFF_FFFC, se);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #4;
            if (state == 3'd3 && last_addr == 32'h1) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reach_word5", 64'(hit), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_state", 64'(state), 64'd0);
        chk("async_outs_a", {mem_address, mem_read, fifo_wdata, fifo_wr_b, fifo_wr_a, mac_clr,
                             mac_en0, fifo_rd_b, busy, done, err}, 64'd0);
        chk("async_perf", 64'(perf_cycles), 64'd0);
        addr_q.delete();
        wq.delete();
        @(posedge clk);
        @(posedge clk);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #4;

        spur_cnt++;
        repeat (3) @(posedge clk);
        #4;
        chk("spur_err", 64'(err), 64'd1);
        chk("spur_state", 64'(state), 64'd0);

        run_job(32'h10, 0, 0, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
